// File: rtl/tc77_responder.sv
// tc77_responder
//   Emulates the serial side of a TC77 temperature sensor for an SPI master.
//   On nCS falling, a 16-bit word {TEMPVAL, TEMPVALID, 2'b00} is snapshotted
//   and shifted out MSB first on SIO.
//   If TC77_CONFIG_WRITE_EN is defined, a 16-bit configuration word written
//   by the master is then shifted in and latched onto CONFIG.
//   Without the macro, CONFIG and SHUTDOWN are tied low.
//
// Ports
//   MCLK      in   system clock; all logic runs on its rising edge
//   RESET     in   synchronous, active-high reset
//   TEMPVAL   in   13-bit two's-complement temperature, 0.0625 C/LSB
//   TEMPVALID in   conversion-complete flag, placed in word bit 2
//   nCS       in   SPI chip select, active-low, asynchronous to MCLK
//   CLK       in   SPI clock (idle high), asynchronous to MCLK
//   SIO       io   serial data; driven only while SIO_OE=1, otherwise Z
//   SIO_OE    out  drive-enable status of SIO
//   nDONE     out  low for one MCLK after the 16th read bit
//   CONFIG    out  last written configuration word
//   SHUTDOWN  out  high when CONFIG == 16'hFFFF
module tc77_responder (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic [12:0] TEMPVAL,
    input  logic        TEMPVALID,
    input  logic        nCS,
    input  logic        CLK,
    inout  logic        SIO,
    output logic        SIO_OE,
    output logic        nDONE,
    output logic [15:0] CONFIG,
    output logic        SHUTDOWN
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SHIFT_OUT = 3'd2,
`ifdef TC77_CONFIG_WRITE_EN
        SHIFT_IN  = 3'd3,
`endif
        HOLD      = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [15:0] tx_word, tx_word_nx;
    logic        sio_oe, sio_oe_nx;
    logic        ndone_q, ndone_nx;

    // Two-flop synchronizers plus one delayed copy for edge detection
    logic ncs_s1, ncs_s2, ncs_d;
    logic clk_s1, clk_s2, clk_d;
    logic [1:0] sync_vld;
    logic       ncs_armed;
    logic       ncs_fall, ncs_rise, clk_rise, clk_fall;

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            ncs_s1    <= 1'b1;
            ncs_s2    <= 1'b1;
            ncs_d     <= 1'b1;
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            clk_d     <= 1'b1;
            sync_vld  <= '0;
            ncs_armed <= 1'b0;
        end else begin
            ncs_s1   <= nCS;
            ncs_s2   <= ncs_s1;
            ncs_d    <= ncs_s2;
            clk_s1   <= CLK;
            clk_s2   <= clk_s1;
            clk_d    <= clk_s2;
            sync_vld <= {sync_vld[0], 1'b1};
            // The reset value of the synchronizer is not a real observation;
            // only arm once nCS has genuinely been seen high.
            if (sync_vld[1] && ncs_s2)
                ncs_armed <= 1'b1;
        end
    end

    assign ncs_fall = ncs_armed & ncs_d & ~ncs_s2;
    assign ncs_rise = ~ncs_d & ncs_s2;
    assign clk_rise = ~clk_d & clk_s2;
    assign clk_fall = clk_d & ~clk_s2;

`ifdef TC77_CONFIG_WRITE_EN
    logic        sio_s1, sio_s2;
    logic [15:0] rx_word, rx_word_nx;
    logic [15:0] config_q, config_nx;

    // SIO is delayed by the same two stages as CLK so the sampled bit lines
    // up with the detected rising edge.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            sio_s1 <= 1'b0;
            sio_s2 <= 1'b0;
        end else begin
            sio_s1 <= SIO;
            sio_s2 <= sio_s1;
        end
    end
`else
    logic unused_sio;
    assign unused_sio = SIO;
`endif

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        tx_word_nx = tx_word;
        sio_oe_nx  = sio_oe;
        ndone_nx   = 1'b1;
`ifdef TC77_CONFIG_WRITE_EN
        rx_word_nx = rx_word;
        config_nx  = config_q;
`endif
        if (state != IDLE && ncs_rise) begin
            // nCS release wins over any CLK edge seen in the same cycle
            state_nx  = IDLE;
            sio_oe_nx = 1'b0;
            cnt_nx    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall)
                        state_nx = LOAD;
                end
                LOAD: begin
                    tx_word_nx = {TEMPVAL, TEMPVALID, 2'b00};
                    sio_oe_nx  = 1'b1;
                    cnt_nx     = '0;
                    state_nx   = SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    if (clk_rise) begin
                        if (cnt == 5'd15) begin
                            ndone_nx  = 1'b0;
                            sio_oe_nx = 1'b0;
                            cnt_nx    = '0;
`ifdef TC77_CONFIG_WRITE_EN
                            state_nx  = SHIFT_IN;
`else
                            state_nx  = HOLD;
`endif
                        end else begin
                            cnt_nx = cnt + 5'd1;
                        end
                    end else if (clk_fall && cnt != 5'd0) begin
                        // Bit 15 is already on the pin from LOAD; the first
                        // falling edge before any rising edge is not a shift.
                        tx_word_nx = {tx_word[14:0], 1'b0};
                    end
                end
`ifdef TC77_CONFIG_WRITE_EN
                SHIFT_IN: begin
                    if (clk_rise) begin
                        rx_word_nx = {rx_word[14:0], sio_s2};
                        if (cnt == 5'd15) begin
                            config_nx = {rx_word[14:0], sio_s2};
                            cnt_nx    = '0;
                            state_nx  = HOLD;
                        end else begin
                            cnt_nx = cnt + 5'd1;
                        end
                    end
                end
`endif
                HOLD: begin
                    sio_oe_nx = 1'b0;
                end
                default: begin
                    state_nx  = IDLE;
                    sio_oe_nx = 1'b0;
                    cnt_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_word <= '0;
            sio_oe  <= 1'b0;
            ndone_q <= 1'b1;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            tx_word <= tx_word_nx;
            sio_oe  <= sio_oe_nx;
            ndone_q <= ndone_nx;
        end
    end

`ifdef TC77_CONFIG_WRITE_EN
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            rx_word  <= '0;
            config_q <= '0;
        end else begin
            rx_word  <= rx_word_nx;
            config_q <= config_nx;
        end
    end

    assign CONFIG   = config_q;
    assign SHUTDOWN = (config_q == 16'hFFFF);
`else
    assign CONFIG   = '0;
    assign SHUTDOWN = 1'b0;
`endif

    assign SIO    = sio_oe ? tx_word[15] : 1'bz;
    assign SIO_OE = sio_oe;
    assign nDONE  = ndone_q;

endmodule

// File: doc/tc77_responder.md
TC77_RESPONDER -- requirements
Module: tc77_responder

Interface
REQ-001 SHALL have port MCLK, input, 1: system clock (48 MHz); all logic on its rising edge.
REQ-002 SHALL have port RESET, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port TEMPVAL, input, 13: two's-complement temperature code, 0.0625 C/LSB.
REQ-004 SHALL have port TEMPVALID, input, 1: conversion-complete flag placed in word bit 2.
REQ-005 SHALL have port nCS, input, 1: SPI chip select, active-low, asynchronous to MCLK.
REQ-006 SHALL have port CLK, input, 1: SPI clock (idle high, up to 6 MHz), asynchronous to MCLK.
REQ-007 SHALL have port SIO, inout, 1: serial data, driven only while SIO_OE=1, otherwise Z.
REQ-008 SHALL have port SIO_OE, output, 1: drive-enable status of SIO.
REQ-009 SHALL have port nDONE, output, 1: low for exactly one MCLK after the 16th read bit is shifted.
REQ-010 SHALL have port CONFIG, output, 16: last written configuration word (macro-dependent, see Configuration).
REQ-011 SHALL have port SHUTDOWN, output, 1: high when CONFIG==16'hFFFF.

Function
REQ-012 SHALL pass nCS and CLK through two-flop synchronizers before any use; edges are detected on the synchronized signals.
REQ-013 SHALL implement states IDLE, LOAD, SHIFT_OUT, SHIFT_IN, HOLD.
REQ-014 IDLE->LOAD on synchronized nCS falling edge; a level-low nCS without a seen high (e.g. after reset) SHALL NOT start a transfer.
REQ-015 LOAD (1 cycle): snapshot word = {TEMPVAL[12:0], TEMPVALID, 2'b00}; set SIO_OE=1 and drive bit 15; bit counter=0; go SHIFT_OUT.
REQ-016 Snapshot SHALL hold for the whole transaction; TEMPVAL changes mid-transfer SHALL NOT affect shifted bits.
REQ-017 SHIFT_OUT: each synchronized CLK rising edge increments the bit counter; each CLK falling edge after at least one rising edge presents the next lower bit, MSB first.
REQ-018 Data change SHALL occur within 4 MCLK of the CLK falling edge at the pin, so it is stable before the master's rising-edge sample.
REQ-019 On the 16th CLK rising edge: nDONE low one cycle, SIO_OE=0, counter=0; go SHIFT_IN if macro defined, else HOLD.
REQ-020 HOLD: SIO released; all CLK edges ignored until nCS rises.
REQ-021 Synchronized nCS rising edge in any non-IDLE state SHALL abort: SIO_OE=0 next cycle, counter cleared, ->IDLE, no nDONE if fewer than 16 bits were shifted.
REQ-022 When nCS rise and a CLK edge are detected in the same cycle, nCS SHALL take priority.
REQ-023 CLK edges while in IDLE SHALL be ignored.
REQ-024 Bit counter is 5 bits; it SHALL NOT wrap within a phase (saturating at the phase end, 16).

Reset
REQ-025 RESET SHALL force state=IDLE, SIO_OE=0 (SIO=Z), nDONE=1, counter=0, CONFIG=0, SHUTDOWN=0, and synchronizers to 1.
REQ-026 RESET asserted mid-transfer SHALL take effect on the next MCLK edge; no partial CONFIG update.

Configuration
REQ-027 Macro TC77_CONFIG_WRITE_EN SHALL compile in the write phase.
REQ-028 With the macro: SHIFT_IN samples SIO on each CLK rising edge into a 16-bit shift register, MSB first; on the 16th bit it loads CONFIG, then goes to HOLD; nCS rising earlier discards the partial word.
REQ-029 Without the macro: no SHIFT_IN state; CONFIG tied 16'h0000; SHUTDOWN tied 0.

Verification
REQ-030 TEMPVAL=13'h0190, TEMPVALID=1, 16 clocks at 6 MHz -> master reads 16'h0C84; nDONE pulses once; SIO=Z afterwards.
REQ-031 Master raises nCS after 14 clocks (existing loader timing) with TEMPVAL=13'h1FF0 -> 14 bits = 14'h3FE1; no nDONE; SIO_OE=0 within 4 MCLK of nCS rise.
REQ-032 TEMPVAL changed to 13'h0000 after bit 3 -> full word still reflects the LOAD snapshot.
REQ-033 Macro defined, 16 read clocks then write 16'hFFFF -> CONFIG=16'hFFFF, SHUTDOWN=1; then write 16'h0000 -> SHUTDOWN=0.
REQ-034 RESET pulsed at bit 8 with nCS held low -> SIO=Z, no further shifting until nCS goes high then low; next transfer is correct.
REQ-035 CLK toggled 5 times with nCS high -> SIO remains Z, state stays IDLE.
